sha3_padder: RTL and testbench
==============================

Name: sha3_padder

Overview:
- Upstream neighbour of the keccak core: converts a byte stream into r-bit message blocks and applies SHA-3 multi-rate padding in hardware.
- Presents each completed block to the core over a valid/ready handshake and flags the final block of each message.
- Replaces bench-side padding so the core can be fed from a UART or file-DMA byte source.

Parameters:
- D, 256, digest width in bits; must match the keccak core's d.
- R, 1600-2*D, rate in bits (1088 at default); R/8 = 136 bytes per block. R must be a multiple of 8.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_byte  input  8  message byte.
- in_valid  input  1  in_byte is valid.
- in_last  input  1  qualifies in_byte as the final byte of the message.
- in_ready  output  1  padder accepts a byte this cycle.
- block  output  R  assembled block. First byte of the block is in block[R-1:R-8]; last byte is in block[7:0].
- block_valid  output  1  block is complete and stable.
- block_last  output  1  block is the final, padded block of the message.
- block_ready  input  1  keccak core consumes the block.

Behaviour:
- Reset values (reset_n low, asynchronous): state ACCEPT; byte counter 0; pend_pad 0; block all zeros; block_valid 0; block_last 0.
- in_ready is 1 only in ACCEPT. After reset release, in_ready is 1 immediately.
- Byte counter: width $clog2(R/8); range 0..R/8-1. Each byte written does block <= {block[R-9:0], byte} and increments the counter.
- Byte transfer: in_valid && in_ready. Block transfer: block_valid && block_ready.
- ACCEPT:
  - Each accepted byte is shifted in.
  - If counter == R/8-1 on acceptance: go to HOLD with block_last=0. Set pend_pad = in_last.
  - Else if in_last: go to PAD.
  - Else: stay in ACCEPT.
- PAD: writes exactly one byte per cycle, no input accepted.
  - Pad byte is 8'h60 for the first pad byte, 8'h01 for position R/8-1, 8'h61 if both apply, else 8'h00. These encodings match the core's bit ordering.
  - After writing position R/8-1: go to HOLD with block_last=1 and clear pend_pad.
- HOLD:
  - block_valid=1; block and block_last are held stable until transfer.
  - On transfer: counter <= 0. Go to PAD if pend_pad, else to ACCEPT.
  - in_ready=0 throughout HOLD.
- Latency:
  - block_valid rises the cycle after the final data byte is written when no padding is needed.
  - Otherwise it rises the cycle after the last pad byte is written: (R/8 - n) PAD cycles, where n is the number of data bytes in the final block.
- Message exactly a multiple of R/8 bytes:
  - The data block is sent with block_last=0.
  - It is followed by a full pad block 60 00 .. 00 01 with block_last=1.
- Zero-length messages are not supported; every message carries at least one byte with in_last.
- No bubbles between messages:
  - After the last-block transfer, ACCEPT resumes the next cycle with counter 0.
  - block contents need not be cleared, since every byte position is overwritten before the next valid.
- in_last without in_valid is ignored. in_byte and in_last are don't-care when in_valid=0.
- Reset mid-operation (any state): immediately return to reset values. The partial block is discarded and no block_valid is produced for it.

Test Plan:
1. One byte 8'hAB with in_last -> after 135 PAD cycles, block_valid=1, block_last=1, block = AB 60 00..00 01 (136 bytes), in_ready=0 until block_ready.
2. 135 bytes 8'h00..8'h86, last on the 135th -> one PAD cycle, block[7:0]=8'h61, block[R-1:R-8]=8'h00, block_last=1.
3. 136 bytes, last on the 136th:
   - first block = the data with block_last=0;
   - after block_ready, 136 PAD cycles, then block = 60 00..00 01 with block_last=1.
4. Backpressure: hold block_ready=0 for 20 cycles in HOLD with in_valid=1 -> block/block_last constant, in_ready=0, no byte lost. The next byte is accepted the cycle after the transfer.
5. 300-byte message of 8'h5A -> three blocks:
   - block 1: all 5A, block_last=0;
   - block 2: all 5A, block_last=0;
   - block 3: 28 x 5A, then 60, zeros, 01, block_last=1.
   - A second 1-byte message immediately after yields a correct padded block.
6. Assert reset_n low during PAD (after 50 data bytes) -> block_valid=0, in_ready=1 after release. A fresh 1-byte message pads correctly with no residue from the aborted message.

Source files
------------

// File: rtl/sha3_padder.sv
// Byte-stream to r-bit block assembler with SHA-3 multi-rate padding.
// Completed blocks are offered over valid/ready; block_last marks the padded final block.
module sha3_padder #(
   parameter int D = 256,
   parameter int R = 1600 - 2 * D
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [7:0]   in_byte,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [R-1:0] block,
   output logic         block_valid,
   output logic         block_last,
   input  logic         block_ready
);

   localparam int NB = R / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST_POS = CW'(NB - 1);

   typedef enum logic [1:0] {
      ACCEPT,
      PAD,
      HOLD
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            pend_reg, pend_next;
   logic            first_reg, first_next;
   logic            last_reg, last_next;
   logic [R-1:0]    block_reg, block_next;
   logic            at_end;
   logic [7:0]      pad_byte;

   assign at_end = (cnt_reg == LAST_POS);
   // 0x60 opens the padding, 0x01 closes it; both collapse to 0x61 in a single-byte pad.
   assign pad_byte = {1'b0, first_reg, first_reg, 4'b0000, at_end};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ACCEPT;
         cnt_reg   <= '0;
         pend_reg  <= 1'b0;
         first_reg <= 1'b0;
         last_reg  <= 1'b0;
         block_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pend_reg  <= pend_next;
         first_reg <= first_next;
         last_reg  <= last_next;
         block_reg <= block_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      pend_next   = pend_reg;
      first_next  = first_reg;
      last_next   = last_reg;
      block_next  = block_reg;
      in_ready    = (state_reg == ACCEPT);
      block_valid = (state_reg == HOLD);

      case (state_reg)
         ACCEPT: begin
            if (in_valid) begin
               block_next = {block_reg[R-9:0], in_byte};
               if (at_end) begin
                  // Full data block: its padding, if any, follows in a block of its own.
                  cnt_next   = '0;
                  state_next = HOLD;
                  last_next  = 1'b0;
                  pend_next  = in_last;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
                  if (in_last) begin
                     state_next = PAD;
                     first_next = 1'b1;
                  end
               end
            end
         end
         PAD: begin
            block_next = {block_reg[R-9:0], pad_byte};
            first_next = 1'b0;
            if (at_end) begin
               cnt_next   = '0;
               state_next = HOLD;
               last_next  = 1'b1;
               pend_next  = 1'b0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         HOLD: begin
            if (block_ready) begin
               cnt_next = '0;
               if (pend_reg) begin
                  state_next = PAD;
                  first_next = 1'b1;
               end else begin
                  state_next = ACCEPT;
               end
            end
         end
         default: state_next = ACCEPT;
      endcase
   end

   assign block      = block_reg;
   assign block_last = last_reg;

endmodule

// File: tb/tb_sha3_padder.sv
// Self-checking bench for sha3_padder: directed scenarios plus randomized messages,
// compared against a padding model built from whole-message byte arithmetic.
module tb_sha3_padder;

   localparam int D  = 256;
   localparam int R  = 1600 - 2 * D;
   localparam int NB = R / 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [7:0]   in_byte = 8'h00;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic         block_ready = 1'b0;
   logic         in_ready;
   logic [R-1:0] block;
   logic         block_valid;
   logic         block_last;

   always #5 clk = ~clk;

   sha3_padder #(.D(D), .R(R)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_byte     (in_byte),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .block       (block),
      .block_valid (block_valid),
      .block_last  (block_last),
      .block_ready (block_ready)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]   msg[$];
   logic [R-1:0] exp_blk[$];
   logic [R-1:0] got_blk[$];
   bit           exp_last[$];
   bit           got_last[$];
   bit           to_flag;
   int           stable_bad, hold_ready_bad, resume_bad, lat;

   // Reference: append 0x60 .. 0x01 so the length becomes a whole number of blocks
   // (a full extra block when the message already is), then cut into blocks.
   task automatic build_expected();
      logic [7:0]   pad[$];
      logic [R-1:0] blk;
      int           len, plen, nblk;
      exp_blk.delete();
      exp_last.delete();
      pad  = msg;
      len  = msg.size();
      plen = NB - (len % NB);
      for (int i = 0; i < plen; i++) pad.push_back(8'h00);
      pad[len] = 8'h60;
      pad[len+plen-1] = pad[len+plen-1] | 8'h01;
      nblk = pad.size() / NB;
      for (int b = 0; b < nblk; b++) begin
         blk = '0;
         for (int i = 0; i < NB; i++) blk[R-1-8*i -: 8] = pad[b*NB+i];
         exp_blk.push_back(blk);
         exp_last.push_back(b == nblk - 1);
      end
   endtask

   // Drives msg through the DUT, collecting blocks and recording protocol observations.
   task automatic send_message(input int hold, input bit rnd);
      int           idx, cyc, hold_cnt, acc_cyc;
      bit           prev_xfer, prev_valid, prev_last, prev_exp_ready, xfer;
      logic [R-1:0] prev_blk;
      idx = 0; cyc = 0; hold_cnt = 0; acc_cyc = -1;
      prev_xfer = 0; prev_valid = 0; prev_last = 0; prev_exp_ready = 0; prev_blk = '0;
      got_blk.delete(); got_last.delete();
      to_flag = 0; stable_bad = 0; hold_ready_bad = 0; resume_bad = 0; lat = -1;
      build_expected();
      while ((idx < msg.size() || got_blk.size() < exp_blk.size()) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (prev_xfer && in_ready !== prev_exp_ready) resume_bad++;
         if (prev_valid && !prev_xfer &&
             (block_valid !== 1'b1 || block !== prev_blk || block_last !== prev_last)) stable_bad++;
         if (block_valid && in_ready) hold_ready_bad++;
         in_valid = (idx < msg.size()) && (!rnd || $urandom_range(0, 3) != 0);
         in_byte  = in_valid ? msg[idx] : 8'($urandom);
         in_last  = in_valid ? (idx == msg.size() - 1) : 1'($urandom);
         if (block_valid) begin
            block_ready = (hold_cnt >= hold) && (!rnd || $urandom_range(0, 1) == 1);
            hold_cnt++;
         end else begin
            block_ready = rnd ? 1'($urandom) : 1'b0;
            hold_cnt = 0;
         end
         #1;
         if (in_valid && in_ready) begin
            if (in_last) acc_cyc = cyc;
            idx++;
         end
         if (block_valid && acc_cyc >= 0 && lat < 0) lat = cyc - acc_cyc;
         xfer = block_valid && block_ready;
         if (xfer) begin
            got_blk.push_back(block);
            got_last.push_back(block_last);
            $display("block %0d last=%0b first=%02h final=%02h", got_blk.size() - 1,
                     block_last, block[R-1 -: 8], block[7:0]);
            prev_exp_ready = block_last || (idx < msg.size());
         end
         prev_xfer = xfer; prev_valid = block_valid; prev_blk = block; prev_last = block_last;
      end
      if (cyc >= 20000) to_flag = 1;
      @(negedge clk);
      if (prev_xfer && in_ready !== prev_exp_ready) resume_bad++;
      in_valid = 1'b0;
      in_last = 1'b0;
      block_ready = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 0; block_ready = 0; reset_n = 0;
      repeat (3) @(negedge clk);
      reset_n = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b exp 1", in_ready); errors++; end
      checks++; if (block_valid !== 1'b0) begin $display("FAIL reset_block_valid got %b exp 0", block_valid); errors++; end
      checks++; if (block_last !== 1'b0) begin $display("FAIL reset_block_last got %b exp 0", block_last); errors++; end
      checks++; if (block !== '0) begin $display("FAIL reset_block got %h exp 0", block[63:0]); errors++; end
   endtask

   task automatic test_one_byte();
      msg.delete();
      msg.push_back(8'hAB);
      send_message(3, 0);
      checks++;
      if (to_flag || got_blk.size() != exp_blk.size()) begin
         $display("FAIL one_byte count got %0d exp %0d timeout %0b", got_blk.size(), exp_blk.size(), to_flag); errors++;
      end else foreach (exp_blk[b]) begin
         checks++;
         if (got_blk[b] !== exp_blk[b] || got_last[b] !== exp_last[b]) begin
            $display("FAIL one_byte blk%0d got %h..%h/%0b exp %h..%h/%0b", b, got_blk[b][R-1 -: 64], got_blk[b][63:0],
                     got_last[b], exp_blk[b][R-1 -: 64], exp_blk[b][63:0], exp_last[b]); errors++;
         end
      end
      checks++; if (lat != NB) begin $display("FAIL one_byte latency got %0d exp %0d", lat, NB); errors++; end
      checks++; if (hold_ready_bad != 0) begin $display("FAIL one_byte in_ready_in_hold got %0d exp 0", hold_ready_bad); errors++; end
      checks++; if (resume_bad != 0) begin $display("FAIL one_byte resume got %0d exp 0", resume_bad); errors++; end
   endtask

   task automatic test_135();
      msg.delete();
      for (int i = 0; i < NB - 1; i++) msg.push_back(8'(i));
      send_message(0, 0);
      checks++;
      if (to_flag || got_blk.size() != exp_blk.size()) begin
         $display("FAIL len135 count got %0d exp %0d timeout %0b", got_blk.size(), exp_blk.size(), to_flag); errors++;
      end else begin
         foreach (exp_blk[b]) begin
            checks++;
            if (got_blk[b] !== exp_blk[b] || got_last[b] !== exp_last[b]) begin
               $display("FAIL len135 blk%0d got %h..%h/%0b exp %h..%h/%0b", b, got_blk[b][R-1 -: 64], got_blk[b][63:0],
                        got_last[b], exp_blk[b][R-1 -: 64], exp_blk[b][63:0], exp_last[b]); errors++;
            end
         end
         checks++; if (got_blk[0][7:0] !== 8'h61) begin $display("FAIL len135 tail got %02h exp 61", got_blk[0][7:0]); errors++; end
         checks++; if (got_blk[0][R-1 -: 8] !== 8'h00) begin $display("FAIL len135 head got %02h exp 00", got_blk[0][R-1 -: 8]); errors++; end
      end
      checks++; if (lat != 2) begin $display("FAIL len135 latency got %0d exp 2", lat); errors++; end
   endtask

   task automatic test_136();
      msg.delete();
      for (int i = 0; i < NB; i++) msg.push_back(8'(i + 7));
      send_message(2, 0);
      checks++;
      if (to_flag || got_blk.size() != 2) begin
         $display("FAIL len136 count got %0d exp 2 timeout %0b", got_blk.size(), to_flag); errors++;
      end else foreach (exp_blk[b]) begin
         checks++;
         if (got_blk[b] !== exp_blk[b] || got_last[b] !== exp_last[b]) begin
            $display("FAIL len136 blk%0d got %h..%h/%0b exp %h..%h/%0b", b, got_blk[b][R-1 -: 64], got_blk[b][63:0],
                     got_last[b], exp_blk[b][R-1 -: 64], exp_blk[b][63:0], exp_last[b]); errors++;
         end
      end
      checks++; if (lat != 1) begin $display("FAIL len136 latency got %0d exp 1", lat); errors++; end
      checks++; if (resume_bad != 0) begin $display("FAIL len136 resume got %0d exp 0", resume_bad); errors++; end
   endtask

   task automatic test_back_pressure();
      msg.delete();
      for (int i = 0; i < 200; i++) msg.push_back(8'($urandom));
      send_message(20, 0);
      checks++;
      if (to_flag || got_blk.size() != exp_blk.size()) begin
         $display("FAIL backpressure count got %0d exp %0d timeout %0b", got_blk.size(), exp_blk.size(), to_flag); errors++;
      end else foreach (exp_blk[b]) begin
         checks++;
         if (got_blk[b] !== exp_blk[b] || got_last[b] !== exp_last[b]) begin
            $display("FAIL backpressure blk%0d got %h..%h/%0b exp %h..%h/%0b", b, got_blk[b][R-1 -: 64], got_blk[b][63:0],
                     got_last[b], exp_blk[b][R-1 -: 64], exp_blk[b][63:0], exp_last[b]); errors++;
         end
      end
      checks++; if (stable_bad != 0) begin $display("FAIL backpressure stable got %0d exp 0", stable_bad); errors++; end
      checks++; if (hold_ready_bad != 0) begin $display("FAIL backpressure in_ready_in_hold got %0d exp 0", hold_ready_bad); errors++; end
      checks++; if (resume_bad != 0) begin $display("FAIL backpressure resume got %0d exp 0", resume_bad); errors++; end
   endtask

   task automatic test_multi_block();
      for (int m = 0; m < 2; m++) begin
         msg.delete();
         for (int i = 0; i < ((m == 0) ? 300 : 1); i++) msg.push_back((m == 0) ? 8'h5A : 8'h3C);
         send_message(0, 0);
         checks++;
         if (to_flag || got_blk.size() != exp_blk.size()) begin
            $display("FAIL multi%0d count got %0d exp %0d timeout %0b", m, got_blk.size(), exp_blk.size(), to_flag); errors++;
         end else foreach (exp_blk[b]) begin
            checks++;
            if (got_blk[b] !== exp_blk[b] || got_last[b] !== exp_last[b]) begin
               $display("FAIL multi%0d blk%0d got %h..%h/%0b exp %h..%h/%0b", m, b, got_blk[b][R-1 -: 64], got_blk[b][63:0],
                        got_last[b], exp_blk[b][R-1 -: 64], exp_blk[b][63:0], exp_last[b]); errors++;
            end
         end
         checks++; if (resume_bad != 0) begin $display("FAIL multi%0d resume got %0d exp 0", m, resume_bad); errors++; end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         in_valid = 1; in_byte = 8'(i + 100); in_last = (i == 49);
      end
      @(negedge clk);
      in_valid = 0; in_last = 0;
      repeat (5) @(negedge clk);
      checks++; if (block_valid !== 1'b0) begin $display("FAIL midreset pad_valid got %b exp 0", block_valid); errors++; end
      reset_n = 0;
      #1;
      checks++; if (block_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL midreset during got valid %b ready %b exp 0 1", block_valid, in_ready); errors++; end
      repeat (2) @(negedge clk);
      reset_n = 1;
      #1;
      checks++; if (in_ready !== 1'b1 || block !== '0) begin
         $display("FAIL midreset release got ready %b block %h exp 1 0", in_ready, block[63:0]); errors++; end
      msg.delete();
      msg.push_back(8'hC3);
      send_message(0, 0);
      checks++;
      if (to_flag || got_blk.size() != 1 || got_blk[0] !== exp_blk[0] || got_last[0] !== 1'b1) begin
         $display("FAIL midreset fresh count %0d timeout %0b", got_blk.size(), to_flag); errors++;
      end
   endtask

   task automatic test_random();
      int len, el;
      for (int m = 0; m < 6; m++) begin
         len = $urandom_range(1, 400);
         msg.delete();
         for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
         send_message(0, 1);
         checks++;
         if (to_flag || got_blk.size() != exp_blk.size()) begin
            $display("FAIL random%0d count got %0d exp %0d timeout %0b", m, got_blk.size(), exp_blk.size(), to_flag); errors++;
         end else foreach (exp_blk[b]) begin
            checks++;
            if (got_blk[b] !== exp_blk[b] || got_last[b] !== exp_last[b]) begin
               $display("FAIL random%0d blk%0d got %h..%h/%0b exp %h..%h/%0b", m, b, got_blk[b][R-1 -: 64], got_blk[b][63:0],
                        got_last[b], exp_blk[b][R-1 -: 64], exp_blk[b][63:0], exp_last[b]); errors++;
            end
         end
         el = (len % NB == 0) ? 1 : NB + 1 - (len % NB);
         checks++; if (lat != el) begin $display("FAIL random%0d latency got %0d exp %0d", m, lat, el); errors++; end
         checks++; if (stable_bad != 0 || hold_ready_bad != 0 || resume_bad != 0) begin
            $display("FAIL random%0d protocol got stable %0d hold %0d resume %0d exp 0", m, stable_bad, hold_ready_bad, resume_bad);
            errors++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_one_byte();
      test_135();
      test_136();
      test_back_pressure();
      test_multi_block();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
